// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and limits for the pipeline hazard unit
package hazard_pkg;

  // Width of the wait down-counter; wide enough for the longest mul/div hold
  localparam int CNT_W = 6;

  // Legal parameter ranges, checked when the top elaborates
  localparam int LOAD_LAT_MIN = 1;
  localparam int LOAD_LAT_MAX = 15;
  localparam int MD_LAT_MIN   = 1;
  localparam int MD_LAT_MAX   = 63;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_MD_WAIT   = 2'd2
  } hazard_state_e;

  // Initial counter value for a wait that lasts 'total' cycles of which
  // 'first' are spent in IDLE before the wait state is entered
  function automatic logic [CNT_W-1:0] wait_init(input int total, input int first);
    int v;
    v = total - first - 1;
    if (v < 0) begin
      v = 0;
    end
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/hazard_down_counter.sv
// rtl/hazard_down_counter.sv - loadable wait down-counter with zero flag
import hazard_pkg::*;

module hazard_down_counter #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load takes priority over decrement; the count never underflows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - load-use, mul/div and branch hazard controller
import hazard_pkg::*;

module hazard_unit_mc #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 34,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_md_start,
  input  logic              branch_taken,
  output logic              stall,
  output logic              id_ex_bubble,
  output logic              ex_hold,
  output logic              if_id_flush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_count
);

  // Reject out-of-range parameters before any simulation or synthesis
  if (LOAD_LAT < LOAD_LAT_MIN || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_load_lat
    $error("hazard_unit_mc: LOAD_LAT out of range");
  end
  if (MD_LAT < MD_LAT_MIN || MD_LAT > MD_LAT_MAX) begin : g_bad_md_lat
    $error("hazard_unit_mc: MD_LAT out of range");
  end
  if (REG_W < 1 || PERF_W < 1) begin : g_bad_width
    $error("hazard_unit_mc: REG_W and PERF_W must be at least 1");
  end

  // The first stall cycle is spent in IDLE; LOAD_WAIT covers the rest
  localparam logic [CNT_W-1:0] LOAD_INIT = wait_init(LOAD_LAT, 1);
  // The mul/div hold is MD_LAT-1 cycles, the first of which is in IDLE
  localparam logic [CNT_W-1:0] MD_INIT   = wait_init(MD_LAT - 1, 1);

  hazard_state_e     r_state;
  hazard_state_e     w_state_nxt;
  logic [PERF_W-1:0] r_stall_count;

  logic              w_hit;
  logic              w_rs1_hit;
  logic              w_rs2_hit;
  logic              w_cnt_zero;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic [CNT_W-1:0]  w_cnt_val;

  logic              w_stall;
  logic              w_bubble;
  logic              w_hold;
  logic              w_flush;
  logic              w_busy;

  // Load-use hazard: the load in EX writes a register the ID instruction reads
  assign w_rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign w_hit     = ex_mem_read && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

  hazard_down_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_dec      (w_cnt_dec),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // Pipeline controls and next state; hazards are answered in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_hold      = 1'b0;
    w_flush     = 1'b0;
    w_busy      = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = '0;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: begin
          if (branch_taken) begin
            // Squash both younger instructions; the branch wins over any hazard
            w_flush  = 1'b1;
            w_bubble = 1'b1;
          end else if (w_hit) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = ST_LOAD_WAIT;
              w_cnt_load  = 1'b1;
              w_cnt_val   = LOAD_INIT;
            end
          end else if (ex_md_start && (MD_LAT > 1)) begin
            w_stall = 1'b1;
            w_hold  = 1'b1;
            w_busy  = 1'b1;
            if (MD_LAT > 2) begin
              w_state_nxt = ST_MD_WAIT;
              w_cnt_load  = 1'b1;
              w_cnt_val   = MD_INIT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
          if (w_cnt_zero) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          w_stall = 1'b1;
          w_hold  = 1'b1;
          w_busy  = 1'b1;
          if (w_cnt_zero) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_dec = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register and stall performance counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
    end
  end

  assign stall        = w_stall;
  assign id_ex_bubble = w_bubble;
  assign ex_hold      = w_hold;
  assign if_id_flush  = w_flush;
  assign md_busy      = w_busy;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - scoreboard bench for hazard_unit_mc over three parameter sets
module tb_hazard_unit_mc;

  localparam int RW = 5;
  localparam int A_LL = 1,  A_ML = 34, A_PW = 32;
  localparam int B_LL = 3,  B_ML = 2,  B_PW = 32;
  localparam int C_LL = 15, C_ML = 1,  C_PW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic          ex_mem_read = 1'b0, ex_md_start = 1'b0, branch_taken = 1'b0;

  logic a_st, a_bb, a_ho, a_fl, a_bz; logic [A_PW-1:0] a_sc;
  logic b_st, b_bb, b_ho, b_fl, b_bz; logic [B_PW-1:0] b_sc;
  logic c_st, c_bb, c_ho, c_fl, c_bz; logic [C_PW-1:0] c_sc;

  hazard_unit_mc #(.REG_W(RW), .LOAD_LAT(A_LL), .MD_LAT(A_ML), .PERF_W(A_PW)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .branch_taken(branch_taken),
    .stall(a_st), .id_ex_bubble(a_bb), .ex_hold(a_ho), .if_id_flush(a_fl),
    .md_busy(a_bz), .stall_count(a_sc));

  hazard_unit_mc #(.REG_W(RW), .LOAD_LAT(B_LL), .MD_LAT(B_ML), .PERF_W(B_PW)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .branch_taken(branch_taken),
    .stall(b_st), .id_ex_bubble(b_bb), .ex_hold(b_ho), .if_id_flush(b_fl),
    .md_busy(b_bz), .stall_count(b_sc));

  hazard_unit_mc #(.REG_W(RW), .LOAD_LAT(C_LL), .MD_LAT(C_ML), .PERF_W(C_PW)) dut_c (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_md_start(ex_md_start), .branch_taken(branch_taken),
    .stall(c_st), .id_ex_bubble(c_bb), .ex_hold(c_ho), .if_id_flush(c_fl),
    .md_busy(c_bz), .stall_count(c_sc));

  // Flag order: stall, id_ex_bubble, ex_hold, if_id_flush, md_busy
  logic [4:0]  act_f [3];
  logic [31:0] act_c [3];
  assign act_f[0] = {a_st, a_bb, a_ho, a_fl, a_bz};
  assign act_f[1] = {b_st, b_bb, b_ho, b_fl, b_bz};
  assign act_f[2] = {c_st, c_bb, c_ho, c_fl, c_bz};
  assign act_c[0] = a_sc;
  assign act_c[1] = b_sc;
  assign act_c[2] = 32'(c_sc);

  typedef struct packed {
    logic [2:0][4:0]  f;
    logic [2:0][31:0] c;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: cycles of stall still owed after the current one
  int p_ll[3];
  int p_ml[3];
  int p_pw[3];
  int load_left[3];
  int md_left[3];
  longint unsigned cnt[3];

  int n_pass  = 0;
  int n_total = 0;

  task automatic cyc(input bit r, input bit br, input bit mr, input bit md,
                     input int rd, input int rs1, input bit u1, input int rs2, input bit u2);
    exp_t e;
    bit hit;
    @(posedge clk);
    #1;
    rst          = r;
    branch_taken = br;
    ex_mem_read  = mr;
    ex_md_start  = md;
    ex_rd        = RW'(rd);
    id_rs1       = RW'(rs1);
    id_rs2       = RW'(rs2);
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    hit = mr && (rd % 32 != 0) && ((u1 && (rs1 % 32 == rd % 32)) || (u2 && (rs2 % 32 == rd % 32)));
    for (int k = 0; k < 3; k++) begin
      bit st, bb, ho, fl, bz;
      st = 0; bb = 0; ho = 0; fl = 0; bz = 0;
      e.c[k] = 32'(cnt[k]);
      if (r) begin
        cnt[k] = 0;
        load_left[k] = 0;
        md_left[k] = 0;
      end else begin
        if (load_left[k] > 0) begin
          st = 1; bb = 1; load_left[k]--;
        end else if (md_left[k] > 0) begin
          st = 1; ho = 1; bz = 1; md_left[k]--;
        end else if (br) begin
          fl = 1; bb = 1;
        end else if (hit) begin
          st = 1; bb = 1; load_left[k] = p_ll[k] - 1;
        end else if (md && p_ml[k] > 1) begin
          st = 1; ho = 1; bz = 1; md_left[k] = p_ml[k] - 2;
        end
        if (st) cnt[k] = (cnt[k] + 1) & ((64'd1 << p_pw[k]) - 1);
      end
      e.f[k] = {st, bb, ho, fl, bz};
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pop one expectation per cycle and compare every DUT away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 3; k++) begin
          n_total++;
          if (act_f[k] === e.f[k]) n_pass++;
          else $display("FAIL flags dut%0d t=%0t: got %b expected %b", k, $time, act_f[k], e.f[k]);
          n_total++;
          if (act_c[k] === e.c[k]) n_pass++;
          else $display("FAIL stall_count dut%0d t=%0t: got %0d expected %0d", k, $time, act_c[k], e.c[k]);
          n_total++;
          if (!(act_f[k][2] && act_f[k][3])) n_pass++;
          else $display("FAIL hold_and_bubble dut%0d t=%0t: got hold=%b bubble=%b expected not both", k, $time, act_f[k][2], act_f[k][3]);
        end
      end
    end
  end

  initial begin
    p_ll = '{A_LL, B_LL, C_LL};
    p_ml = '{A_ML, B_ML, C_ML};
    p_pw = '{A_PW, B_PW, C_PW};
    for (int k = 0; k < 3; k++) begin
      load_left[k] = 0; md_left[k] = 0; cnt[k] = 0;
    end

    // Reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load-use via rs2, then idle long enough for the 15-cycle variant to finish
    cyc(0, 0, 1, 0, 5, 0, 0, 5, 1);
    idle(17);
    // No hazard: destination x0, and unused rs1 with matching index
    cyc(0, 0, 1, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 7, 7, 0, 3, 1);
    idle(2);
    // Branch taken together with a load-use hit
    cyc(0, 1, 1, 0, 9, 9, 1, 0, 0);
    idle(2);
    // Mul/div pulse held for its full occupancy
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(36);
    // Reset in the 10th cycle of the mul/div wait, then a hit right after
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(9);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 1, 0, 4, 4, 1, 0, 0);
    idle(16);

    // Random traffic; a load and a mul/div start never come from the same instruction
    for (int i = 0; i < 2500; i++) begin
      bit r, br, mr, md, u1, u2;
      int sel;
      r   = ($urandom_range(0, 199) == 0);
      br  = ($urandom_range(0, 9) == 0);
      sel = $urandom_range(0, 19);
      mr  = (sel < 7);
      md  = (sel == 7);
      u1  = $urandom_range(0, 1);
      u2  = $urandom_range(0, 1);
      cyc(r, br, mr, md, $urandom_range(0, 3), $urandom_range(0, 3), u1,
          $urandom_range(0, 3), u2);
    end
    idle(2);

    repeat (3) @(posedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use stall cycles (legal 1..15).
REQ-003 SHALL have parameter MD_LAT, default 34, mul/div EX occupancy in cycles (legal 1..63).
REQ-004 SHALL have parameter PERF_W, default 32, stall performance-counter width.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- id_rs1, id_rs2  in  REG_W  source indices of the instruction in IF/ID.
- id_uses_rs1, id_uses_rs2  in  1  source actually read.
- ex_rd  in  REG_W  destination of the instruction in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_md_start  in  1  ID/EX instruction is MUL/DIV, first EX cycle.
- branch_taken  in  1  branch/jump resolved taken in EX.
- stall  out  1  hold PC and IF/ID.
- id_ex_bubble  out  1  load ID/EX with NOP.
- ex_hold  out  1  hold ID/EX and EX stage.
- if_id_flush  out  1  load IF/ID with NOP.
- md_busy  out  1  mul/div occupying EX.
- stall_count  out  PERF_W  cycles with stall=1 since reset.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD_WAIT, MD_WAIT with a 6-bit down-counter cnt.
REQ-007 SHALL define hit = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
REQ-008 IDLE, branch_taken=1: if_id_flush=1, id_ex_bubble=1, stall=0; hit and ex_md_start ignored that cycle; stay IDLE.
REQ-009 IDLE, hit=1, no branch: stall=1, id_ex_bubble=1 combinationally same cycle; LOAD_LAT=1 stays IDLE, else go LOAD_WAIT, cnt=LOAD_LAT-2.
REQ-010 LOAD_WAIT: stall=1, id_ex_bubble=1; cnt=0 -> IDLE, else cnt decrements; total stall exactly LOAD_LAT consecutive cycles.
REQ-011 IDLE, ex_md_start=1, no branch, MD_LAT>1: stall=1, ex_hold=1, md_busy=1 same cycle; MD_LAT=2 stays IDLE, else go MD_WAIT, cnt=MD_LAT-3.
REQ-012 MD_WAIT: stall=1, ex_hold=1, md_busy=1, id_ex_bubble=0; cnt=0 -> IDLE, else decrement; total hold exactly MD_LAT-1 cycles.
REQ-013 MD_LAT=1: ex_md_start SHALL produce no stall.
REQ-014 In LOAD_WAIT/MD_WAIT, hit, ex_md_start and branch_taken SHALL be ignored (cannot legally occur).
REQ-015 Return to IDLE SHALL re-evaluate hit/branch/md_start in that IDLE cycle with no dead cycle.
REQ-016 ex_hold and id_ex_bubble SHALL never be 1 in the same cycle.
REQ-017 stall_count SHALL increment by 1 each cycle stall=1, wrapping modulo 2^PERF_W.

Reset
REQ-018 rst=1 SHALL force state IDLE, cnt=0, stall_count=0 on the next edge, aborting any wait mid-operation.
REQ-019 While rst=1, stall, id_ex_bubble, ex_hold, if_id_flush, md_busy SHALL all be 0.

Structure
REQ-020 Package hazard_pkg SHALL hold the state enum, CNT_W=6, and the LOAD_LAT/MD_LAT legal bounds.
REQ-021 The wait counter SHALL be sub-module hazard_down_counter (load, decrement, zero flag).
REQ-022 Illegal parameters SHALL be caught by elaboration-time check.

Verification
REQ-023 LOAD_LAT=1, ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> stall=1, id_ex_bubble=1 one cycle; stall_count=1.
REQ-024 LOAD_LAT=3, same hit -> stall and bubble high exactly 3 cycles, then IDLE; stall_count=3.
REQ-025 ex_rd=0 or id_uses_rs1=0 with matching index -> no stall.
REQ-026 MD_LAT=34, ex_md_start pulse -> stall, ex_hold, md_busy high exactly 33 cycles, id_ex_bubble=0 throughout.
REQ-027 branch_taken=1 with hit=1 same cycle -> if_id_flush=1, id_ex_bubble=1, stall=0.
REQ-028 rst=1 at 10th MD_WAIT cycle -> next cycle all outputs 0, stall_count=0, state IDLE.
